rr_arb5: RTL and testbench

- Five-requester round-robin arbiter that shares one downstream resource (a gate/LUT-level datapath slice) between five masters.
- Grants one master at a time, holds the grant until that master releases, then enforces one dead cycle before re-arbitration.
- Also exports an all-requesting flag, built from the library NOR5B5 cell (5-input NOR, all inputs inverted, i.e. AND of all five), for contention monitors.
- Sits between requester FSMs and the shared resource mux.

---
 rtl/rr_arb5_pkg.sv | 13 +
 rtl/NOR5B5.sv | 13 +
 rtl/rr_arb5_pick.sv | 44 ++++
 rtl/rr_arb5.sv | 173 +++++++++++++++++
 tb/tb_rr_arb5.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb5_pkg.sv
// Shared types and defaults for the rr_arb5 five-master round-robin arbiter.
package rr_arb5_pkg;

    localparam int STATE_W      = 2;
    localparam int HOLD_MAX_DEF = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/NOR5B5.sv
// Library cell model: 5-input NOR with all inputs inverted (logical AND of I0..I4).
module NOR5B5 (
    input  logic I0,
    input  logic I1,
    input  logic I2,
    input  logic I3,
    input  logic I4,
    output logic O
);

    assign O = ~(~I0 | ~I1 | ~I2 | ~I3 | ~I4);

endmodule

// File: rtl/rr_arb5_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping modulo N.
module rr_arb5_pick #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    always_comb begin
        // Doubling the vector lets a plain shift act as a modulo-N rotate.
        dbl = {req, req};
        rot = N'(dbl >> ptr);

        any = 1'b0;
        off = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                off = IDX_W'(i);
            end
        end

        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDX_W+1)'(N)) begin
            sum = sum - (IDX_W+1)'(N);
        end
        win_idx = sum[IDX_W-1:0];

        win = '0;
        for (int unsigned i = 0; i < N; i++) begin
            win[i] = any && (win_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/rr_arb5.sv
// Five-master round-robin arbiter with grant hold, one dead cycle between grants,
// and an all-requesting flag. Optional grant timeout: define RR_ARB5_TIMEOUT_EN.
module rr_arb5
    import rr_arb5_pkg::*;
#(
    parameter int N        = 5,
    parameter int IDX_W    = 3,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic             C,
    input  logic             R,
    input  logic [N-1:0]     REQ,
    output logic [N-1:0]     GNT,
    output logic             GNT_VLD,
    output logic [IDX_W-1:0] GNT_IDX,
    output logic             ALL_REQ,
    output logic             TMO
);

    generate
        if (N != 5) begin : g_bad_n
            $error("rr_arb5: only N=5 is supported");
        end
        if ((1 << IDX_W) < N) begin : g_bad_idx_w
            $error("rr_arb5: IDX_W too narrow for N");
        end
        if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
            $error("rr_arb5: HOLD_MAX must be in 1..255");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic             vld_q, vld_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [N-1:0]     pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             req_cur;
    logic             take;
    logic             rel;

`ifdef RR_ARB5_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;
    logic       expire;

    assign expire = (cnt_q == 8'(HOLD_MAX - 1));
`endif

    rr_arb5_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (REQ),
        .ptr     (ptr_q),
        .win     (pick_gnt),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    NOR5B5 u_all_req (
        .I0 (REQ[0]),
        .I1 (REQ[1]),
        .I2 (REQ[2]),
        .I3 (REQ[3]),
        .I4 (REQ[4]),
        .O  (ALL_REQ)
    );

    assign req_cur = REQ[idx_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        idx_d   = idx_q;
        take    = 1'b0;
        rel     = 1'b0;
`ifdef RR_ARB5_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                take = pick_any;
            end
            ST_GRANT: begin
                if (!req_cur) begin
                    rel = 1'b1;
                end
`ifdef RR_ARB5_TIMEOUT_EN
                else if (expire) begin
                    rel   = 1'b1;
                    tmo_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            ST_GAP: begin
                take = pick_any;
                if (!pick_any) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                vld_d   = 1'b0;
            end
        endcase

        if (take) begin
            state_d = ST_GRANT;
            gnt_d   = pick_gnt;
            vld_d   = 1'b1;
            idx_d   = pick_idx;
`ifdef RR_ARB5_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end

        // Forced and natural releases share this path; the released master drops to lowest priority.
        if (rel) begin
            state_d = ST_GAP;
            gnt_d   = '0;
            vld_d   = 1'b0;
            ptr_d   = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
        end
    end

`ifdef RR_ARB5_TIMEOUT_EN
    always_ff @(posedge C) begin
        if (R) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign TMO = tmo_q;
`else
    assign TMO = 1'b0;
`endif

    assign GNT     = gnt_q;
    assign GNT_VLD = vld_q;
    assign GNT_IDX = idx_q;

endmodule

// File: tb/tb_rr_arb5.sv
// Scoreboard bench for rr_arb5: stimulus queues expected grants, a monitor checks each grant.
module tb_rr_arb5;

`ifdef RR_ARB5_TIMEOUT_EN
    localparam int HM = 4;
`else
    localparam int HM = 16;
`endif

    typedef struct {
        int idx;
        int gap;
        int len;
        bit tmo;
    } exp_t;

    logic       C = 1'b0;
    logic       R = 1'b1;
    logic [4:0] REQ = '0;
    logic [4:0] GNT;
    logic       GNT_VLD;
    logic [2:0] GNT_IDX;
    logic       ALL_REQ;
    logic       TMO;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 C = ~C;

    rr_arb5 #(
        .N        (5),
        .IDX_W    (3),
        .HOLD_MAX (HM)
    ) dut (
        .C       (C),
        .R       (R),
        .REQ     (REQ),
        .GNT     (GNT),
        .GNT_VLD (GNT_VLD),
        .GNT_IDX (GNT_IDX),
        .ALL_REQ (ALL_REQ),
        .TMO     (TMO)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge C);
        #1;
    endtask

    // gap < 0 or len == 0 means "don't care"
    function automatic void push(input int idx, input int gap, input int len, input bit tmo);
        exp_t e;
        e.idx = idx;
        e.gap = gap;
        e.len = len;
        e.tmo = tmo;
        q.push_back(e);
    endfunction

    initial begin
        bit   prev  = 1'b0;
        int   run   = 0;
        int   zeros = 0;
        exp_t cur;
        cur.idx = 0; cur.gap = -1; cur.len = 0; cur.tmo = 1'b0;
        forever begin
            @(negedge C);
            if (GNT_VLD && !prev) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grant: got idx %0d want no grant", GNT_IDX);
                    cur.idx = GNT_IDX; cur.gap = -1; cur.len = 0; cur.tmo = 1'b0;
                end else begin
                    cur = q.pop_front();
                    chk("gnt_idx", int'(GNT_IDX), cur.idx);
                    chk("gnt_onehot", int'(GNT), 1 << cur.idx);
                    if (cur.gap >= 0) chk("gap_cycles", zeros, cur.gap);
                end
                run = 1;
                chk("tmo_quiet", int'(TMO), 0);
            end else if (GNT_VLD) begin
                run++;
                chk("gnt_held", int'(GNT), 1 << cur.idx);
                chk("tmo_quiet", int'(TMO), 0);
            end else if (prev) begin
                if (cur.len > 0) chk("grant_len", run, cur.len);
                chk("tmo_on_release", int'(TMO), int'(cur.tmo));
                chk("gnt_cleared", int'(GNT), 0);
            end else begin
                chk("tmo_quiet", int'(TMO), 0);
                chk("gnt_idle_zero", int'(GNT), 0);
            end
            zeros = GNT_VLD ? 0 : zeros + 1;
            prev  = GNT_VLD;
        end
    end

    initial begin
        tick;
        tick;
        chk("rst_gnt", int'(GNT), 0);
        chk("rst_vld", int'(GNT_VLD), 0);
        chk("rst_idx", int'(GNT_IDX), 0);
        chk("rst_tmo", int'(TMO), 0);
        chk("rst_all_req", int'(ALL_REQ), 0);
        R = 1'b0;

        // single request, release, GAP, IDLE
        REQ = 5'b00100;
        push(2, -1, 1, 1'b0);
        tick;
        REQ = '0;
        tick;
        chk("idx_holds_after_release", int'(GNT_IDX), 2);
        tick;
        tick;
        chk("idle_after_gap", int'(GNT_VLD), 0);

        // all requesting, rotation 0..4,0 with one dead cycle each
        R = 1'b1;
        tick;
        R = 1'b0;
        REQ = '1;
        for (int k = 0; k < 6; k++) begin
            int g;
            g = k % 5;
            push(g, (k == 0) ? -1 : 1, 3, 1'b0);
            tick;
            chk("all_req_hi", int'(ALL_REQ), 1);
            tick;
            tick;
            REQ[g] = 1'b0;
            #1;
            chk("all_req_lo", int'(ALL_REQ), 0);
            tick;
            if (k < 5) REQ[g] = 1'b1;
            else       REQ = '0;
        end
        tick;

        // pointer wrap after master 4 releases
        REQ = 5'b00010;
        push(1, -1, 1, 1'b0);
        tick;
        REQ = '0;
        tick;
        REQ = 5'b10011;
        push(4, 1, 2, 1'b0);
        tick;
        tick;
        REQ = 5'b00011;
        push(0, 1, 1, 1'b0);
        tick;
        tick;
        REQ = '0;
        tick;
        tick;

        // reset mid-grant: no GAP, pointer back to 0
        REQ = 5'b01000;
        push(3, -1, 0, 1'b0);
        tick;
        tick;
        R = 1'b1;
        tick;
        chk("midrst_gnt", int'(GNT), 0);
        chk("midrst_vld", int'(GNT_VLD), 0);
        chk("midrst_idx", int'(GNT_IDX), 0);
        chk("midrst_tmo", int'(TMO), 0);
        R = 1'b0;
        REQ = 5'b01001;
        push(0, 1, 1, 1'b0);
        tick;
        REQ = '0;
        tick;
        tick;

`ifdef RR_ARB5_TIMEOUT_EN
        R = 1'b1;
        tick;
        R = 1'b0;
        REQ = 5'b00010;
        push(1, -1, 4, 1'b1);
        push(1, 1, 4, 1'b0);
        tick;
        tick;
        tick;
        tick;
        tick;
        chk("tmo_pulse", int'(TMO), 1);
        tick;
        chk("tmo_one_cycle", int'(TMO), 0);
        tick;
        tick;
        tick;
        REQ = '0;
        tick;
        chk("natural_on_expiry_tmo", int'(TMO), 0);
        tick;
        tick;
`else
        REQ = 5'b00100;
        push(2, -1, 301, 1'b0);
        tick;
        repeat (300) tick;
        chk("long_hold_gnt", int'(GNT), 5'b00100);
        chk("long_hold_tmo", int'(TMO), 0);
        REQ = '0;
        tick;
        tick;
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) tick;
        chk("queue_drained", q.size(), 0);
        tick;
        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
